// File: rtl/bcd_cook_timer.sv
// bcd_cook_timer: BCD MM:SS countdown timer with keypad entry, prescaled tick, run/pause FSM and +30 s add
module bcd_cook_timer #(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV = 100
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [3:0]              digit,
  input  logic                    digit_valid,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  input  logic                    add30,
  output logic [3:0]              units_sec,
  output logic [3:0]              tens_sec,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic                    running,
  output logic                    paused,
  output logic                    done,
  output logic                    zero
);
  localparam int TW = 4 * MIN_DIGITS + 8;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tm, tm_nxt, tm_dec;
  logic [PW-1:0] presc, presc_nxt;
  logic done_nxt, tick;
  function automatic logic [TW-1:0] dec_f(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        for (int i = 0; i < MIN_DIGITS; i++) begin
          if (b) begin
            r[8+4*i +: 4] = v[8+4*i +: 4] == 4'd0 ? 4'd9 : v[8+4*i +: 4] - 4'd1;
            b = v[8+4*i +: 4] == 4'd0;
          end
        end
      end
    end
    return r;
  endfunction
  function automatic logic [TW-1:0] add_f(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic [3:0] t;
    logic c;
    r = v;
    t = v[7:4] + 4'd3;
    c = t > 4'd5;
    r[7:4] = c ? t - 4'd6 : t;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (c) begin
        r[8+4*i +: 4] = v[8+4*i +: 4] == 4'd9 ? 4'd0 : v[8+4*i +: 4] + 4'd1;
        c = v[8+4*i +: 4] == 4'd9;
      end
    end
    if (c) r = {{MIN_DIGITS{4'd9}}, 4'd5, 4'd9};
    return r;
  endfunction
  assign tick = state == RUN && presc == PW'(TICK_DIV - 1);
  assign tm_dec = tick ? dec_f(tm) : tm;
  always_comb begin
    state_nxt = state;
    tm_nxt = tm;
    presc_nxt = presc;
    done_nxt = 1'b0;
    if (cancel) begin
      state_nxt = IDLE;
      tm_nxt = '0;
    end else if (pause) state_nxt = state == RUN ? PAUSE : state;
    else if (state == RUN) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      tm_nxt = add30 ? add_f(tm_dec) : tm_dec;
      if (!add30 && tick && tm_dec == '0) begin
        state_nxt = IDLE;
        done_nxt = 1'b1;
      end
    end else if (add30) begin
      tm_nxt = add_f(tm);
      state_nxt = state == IDLE ? RUN : state;
      presc_nxt = state == IDLE ? '0 : presc;
    end else if (start && (state == PAUSE || tm != '0)) begin
      state_nxt = RUN;
      presc_nxt = '0;
    end else if (state == IDLE && digit_valid && digit <= 4'd9) tm_nxt = {tm[TW-5:0], digit};
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      tm <= '0;
      presc <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      tm <= tm_nxt;
      presc <= presc_nxt;
      done <= done_nxt;
    end
  end
  assign {minutes, tens_sec, units_sec} = tm;
  assign running = state == RUN;
  assign paused = state == PAUSE;
  assign zero = tm == '0;
endmodule

// File: tb/tb_bcd_cook_timer.sv
// tb_bcd_cook_timer: vector table plus scoreboarded sequences for the BCD cook timer
module tb_bcd_cook_timer;
  localparam int MD = 2;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic clear = 1'b1;
  logic [3:0] digit = 4'd0;
  logic digit_valid = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0, add30 = 1'b0;
  logic [3:0] units_sec, tens_sec;
  logic [4*MD-1:0] minutes;
  logic running, paused, done, zero;
  always #5 clk = ~clk;
  bcd_cook_timer #(.MIN_DIGITS(MD), .TICK_DIV(TD)) dut (
    .clk(clk), .clear(clear), .digit(digit), .digit_valid(digit_valid), .start(start),
    .pause(pause), .cancel(cancel), .add30(add30), .units_sec(units_sec), .tens_sec(tens_sec),
    .minutes(minutes), .running(running), .paused(paused), .done(done), .zero(zero)
  );
  typedef struct {
    logic [3:0] dg;
    logic dv, st, pa, ca, ad;
    logic [15:0] t;
    logic [1:0] rp;
    logic dn;
  } vec_t;
  typedef struct {
    logic [15:0] t;
    logic [1:0] rp;
    logic dn;
    logic z;
    string nm;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  int n_cmp = 0;
  int n_err = 0;
  function automatic vec_t mk(input logic [3:0] dg, input logic dv, input logic st, input logic pa,
                              input logic ca, input logic ad, input logic [15:0] t,
                              input logic [1:0] rp, input logic dn);
    vec_t v;
    v.dg = dg; v.dv = dv; v.st = st; v.pa = pa; v.ca = ca; v.ad = ad;
    v.t = t; v.rp = rp; v.dn = dn;
    return v;
  endfunction
  task automatic expect_now(input string nm, input logic [15:0] t, input logic [1:0] rp, input logic dn);
    exp_t e;
    e.t = t; e.rp = rp; e.dn = dn; e.z = t == 16'h0000; e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic compare_out();
    exp_t e;
    logic [15:0] act;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    act = {minutes, tens_sec, units_sec};
    if (act !== e.t || {running, paused} !== e.rp || done !== e.dn || zero !== e.z) begin
      n_err++;
      $display("FAIL %s: got t=%h run/pause=%b done=%b zero=%b, want t=%h run/pause=%b done=%b zero=%b",
               e.nm, act, {running, paused}, done, zero, e.t, e.rp, e.dn, e.z);
    end
  endtask
  task automatic step(input vec_t v, input string nm);
    digit = v.dg; digit_valid = v.dv; start = v.st; pause = v.pa; cancel = v.ca; add30 = v.ad;
    expect_now(nm, v.t, v.rp, v.dn);
    @(posedge clk);
    #1;
    compare_out();
  endtask
  task automatic idle(input int n, input logic [15:0] t, input logic [1:0] rp, input string nm);
    for (int i = 0; i < n; i++) step(mk(4'd0, 0, 0, 0, 0, 0, t, rp, 0), nm);
  endtask
  task automatic key(input logic [3:0] d, input logic [15:0] t, input string nm);
    step(mk(d, 1, 0, 0, 0, 0, t, 2'b00, 0), nm);
  endtask
  task automatic go(input logic [15:0] t, input string nm);
    step(mk(4'd0, 0, 1, 0, 0, 0, t, 2'b10, 0), nm);
  endtask
  task automatic cxl(input string nm);
    step(mk(4'd0, 0, 0, 0, 1, 0, 16'h0000, 2'b00, 0), nm);
  endtask
  initial begin
    int n;
    tbl.push_back(mk(4'd1, 1, 0, 0, 0, 0, 16'h0001, 2'b00, 0));
    tbl.push_back(mk(4'd3, 1, 0, 0, 0, 0, 16'h0013, 2'b00, 0));
    tbl.push_back(mk(4'd0, 1, 0, 0, 0, 0, 16'h0130, 2'b00, 0));
    tbl.push_back(mk(4'hA, 1, 0, 0, 0, 0, 16'h0130, 2'b00, 0));
    tbl.push_back(mk(4'd0, 0, 1, 1, 0, 0, 16'h0130, 2'b00, 0));
    tbl.push_back(mk(4'd0, 0, 0, 0, 1, 0, 16'h0000, 2'b00, 0));
    tbl.push_back(mk(4'd0, 0, 1, 0, 0, 0, 16'h0000, 2'b00, 0));
    tbl.push_back(mk(4'd4, 1, 0, 0, 0, 0, 16'h0004, 2'b00, 0));
    tbl.push_back(mk(4'd5, 1, 0, 0, 0, 0, 16'h0045, 2'b00, 0));
    tbl.push_back(mk(4'd7, 1, 1, 0, 0, 1, 16'h0115, 2'b10, 0));
    tbl.push_back(mk(4'd0, 0, 1, 1, 0, 0, 16'h0115, 2'b01, 0));
    tbl.push_back(mk(4'd2, 1, 0, 0, 0, 1, 16'h0145, 2'b01, 0));
    tbl.push_back(mk(4'd2, 1, 0, 0, 0, 0, 16'h0145, 2'b01, 0));
    tbl.push_back(mk(4'd0, 0, 1, 1, 1, 0, 16'h0000, 2'b00, 0));
    tbl.push_back(mk(4'd1, 1, 0, 0, 0, 0, 16'h0001, 2'b00, 0));
    tbl.push_back(mk(4'd2, 1, 0, 0, 0, 0, 16'h0012, 2'b00, 0));
    tbl.push_back(mk(4'd3, 1, 0, 0, 0, 0, 16'h0123, 2'b00, 0));
    tbl.push_back(mk(4'd4, 1, 0, 0, 0, 0, 16'h1234, 2'b00, 0));
    tbl.push_back(mk(4'd5, 1, 0, 0, 0, 0, 16'h2345, 2'b00, 0));
    tbl.push_back(mk(4'd0, 0, 0, 0, 1, 0, 16'h0000, 2'b00, 0));
    tbl.push_back(mk(4'd9, 1, 0, 0, 0, 0, 16'h0009, 2'b00, 0));
    tbl.push_back(mk(4'd9, 1, 0, 0, 0, 0, 16'h0099, 2'b00, 0));
    tbl.push_back(mk(4'd5, 1, 0, 0, 0, 0, 16'h0995, 2'b00, 0));
    tbl.push_back(mk(4'd0, 1, 0, 0, 0, 0, 16'h9950, 2'b00, 0));
    tbl.push_back(mk(4'd0, 0, 0, 0, 0, 1, 16'h9959, 2'b10, 0));
    tbl.push_back(mk(4'd0, 0, 0, 0, 1, 0, 16'h0000, 2'b00, 0));
    tbl.push_back(mk(4'd0, 0, 0, 0, 0, 1, 16'h0030, 2'b10, 0));
    tbl.push_back(mk(4'd0, 0, 0, 0, 1, 0, 16'h0000, 2'b00, 0));
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset", 16'h0000, 2'b00, 0);
    compare_out();
    clear = 1'b0;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));
    key(4'd0, 16'h0000, "cd_key"); key(4'd0, 16'h0000, "cd_key"); key(4'd5, 16'h0005, "cd_key");
    go(16'h0005, "cd_start");
    for (int k = 1; k <= 5 * TD; k++)
      step(mk(4'd0, 0, 0, 0, 0, 0, {12'h000, 4'(5 - k / TD)}, k < 5 * TD ? 2'b10 : 2'b00, k == 5 * TD),
           $sformatf("cd_cycle%0d", k));
    idle(1, 16'h0000, 2'b00, "cd_done_drop");
    key(4'd2, 16'h0002, "br_key"); key(4'd0, 16'h0020, "br_key"); key(4'd0, 16'h0200, "br_key");
    go(16'h0200, "br_start");
    idle(TD - 1, 16'h0200, 2'b10, "br_wait");
    idle(1, 16'h0159, 2'b10, "br_borrow");
    cxl("br_cancel");
    key(4'd9, 16'h0009, "s99_key"); key(4'd9, 16'h0099, "s99_key");
    go(16'h0099, "s99_start");
    n = 99;
    for (int c = 1; c <= 40 * TD; c++) begin
      if (c % TD == 0) n--;
      step(mk(4'd0, 0, 0, 0, 0, 0, {8'h00, 4'(n / 10), 4'(n % 10)}, 2'b10, 0), $sformatf("s99_at%0d", n));
    end
    cxl("s99_cancel");
    key(4'd2, 16'h0002, "pz_key"); key(4'd0, 16'h0020, "pz_key");
    go(16'h0020, "pz_start");
    idle(TD - 1, 16'h0020, 2'b10, "pz_wait");
    step(mk(4'd0, 0, 0, 1, 0, 0, 16'h0020, 2'b01, 0), "pz_pause_on_tick");
    idle(10, 16'h0020, 2'b01, "pz_frozen");
    go(16'h0020, "pz_resume");
    idle(TD - 1, 16'h0020, 2'b10, "pz_resume_wait");
    idle(1, 16'h0019, 2'b10, "pz_first_dec");
    step(mk(4'd0, 0, 0, 1, 0, 0, 16'h0019, 2'b01, 0), "pz_pause2");
    cxl("pz_cancel");
    idle(1, 16'h0000, 2'b00, "pz_no_done");
    key(4'd1, 16'h0001, "ad_key");
    go(16'h0001, "ad_start");
    idle(TD - 1, 16'h0001, 2'b10, "ad_wait");
    step(mk(4'd0, 0, 0, 0, 0, 1, 16'h0030, 2'b10, 0), "ad_tick_add30");
    idle(TD - 1, 16'h0030, 2'b10, "ad_after");
    idle(1, 16'h0029, 2'b10, "ad_dec");
    cxl("ad_cancel");
    key(4'd1, 16'h0001, "tc_key");
    go(16'h0001, "tc_start");
    idle(TD - 1, 16'h0001, 2'b10, "tc_wait");
    cxl("tc_tick_cancel");
    idle(1, 16'h0000, 2'b00, "tc_no_done");
    key(4'd1, 16'h0001, "cl_key");
    go(16'h0001, "cl_start");
    idle(TD - 1, 16'h0001, 2'b10, "cl_wait");
    clear = 1'b1;
    #2;
    expect_now("cl_async", 16'h0000, 2'b00, 0);
    compare_out();
    @(posedge clk);
    #1;
    expect_now("cl_held", 16'h0000, 2'b00, 0);
    compare_out();
    clear = 1'b0;
    idle(1, 16'h0000, 2'b00, "cl_release");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
